// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package fetch_pkg;

    localparam int unsigned INSN_W = 32;
    localparam logic [INSN_W-1:0] NOP_INSN = 32'h0000_0013;

    typedef enum logic [1:0] {
        BOOT,
        REQ,
        WAIT,
        HOLD
    } fetch_state_t;

    function automatic logic is_word_aligned(input logic [1:0] lsb);
        return lsb == 2'b00;
    endfunction

endpackage

// File: rtl/fetch_if.sv
// Instruction-memory request/response bus between the fetch stage and imem.
interface fetch_if #(
    parameter int unsigned XLEN = 32
);
    logic            req;
    logic [XLEN-1:0] addr;
    logic            gnt;
    logic            rvalid;
    logic [XLEN-1:0] rdata;
    logic            err;

    modport master (
        output req,
        output addr,
        input  gnt,
        input  rvalid,
        input  rdata,
        input  err
    );

    modport slave (
        input  req,
        input  addr,
        output gnt,
        output rvalid,
        output rdata,
        output err
    );
endinterface

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: one outstanding imem request, one held instruction,
// redirect handling with a kill flag for in-flight responses.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int unsigned     XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_stall_fc,
    input  logic             i_redirect_valid,
    input  logic [XLEN-1:0]  i_redirect_pc,
    fetch_if.master          imem,
    output logic             o_fetch_ready,
    output logic [XLEN-1:0]  o_instr,
    output logic [XLEN-1:0]  o_pc_out,
    output logic             o_fetch_fault,
    output logic [31:0]      o_fetch_count
);

    localparam logic [XLEN-1:0] NOP_WORD = XLEN'(NOP_INSN);

    fetch_state_t    r_state;
    logic [XLEN-1:0] r_pc;
    logic            r_kill;
    logic            r_fetch_ready;
    logic [XLEN-1:0] r_instr;
    logic [XLEN-1:0] r_pc_out;
    logic            r_fetch_fault;
    logic [31:0]     r_fetch_count;

    logic w_aligned;
    logic w_req;
    logic w_gnt;

    // A misaligned pc never goes on the bus; REQ turns it into a fault instead.
    assign w_aligned = is_word_aligned(r_pc[1:0]);
    assign w_req     = (r_state == REQ) && w_aligned;
    assign w_gnt     = w_req && imem.gnt;

    assign imem.req  = w_req;
    assign imem.addr = r_pc;

    assign o_fetch_ready = r_fetch_ready;
    assign o_instr       = r_instr;
    assign o_pc_out      = r_pc_out;
    assign o_fetch_fault = r_fetch_fault;
    assign o_fetch_count = r_fetch_count;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state       <= BOOT;
            r_pc          <= RESET_PC;
            r_kill        <= 1'b0;
            r_fetch_ready <= 1'b0;
            r_instr       <= NOP_WORD;
            r_pc_out      <= RESET_PC;
            r_fetch_fault <= 1'b0;
            r_fetch_count <= '0;
        end else begin
            unique case (r_state)
                BOOT: begin
                    r_state <= REQ;
                    if (i_redirect_valid) begin
                        r_pc <= i_redirect_pc;
                    end
                end

                REQ: begin
                    if (i_redirect_valid) begin
                        r_pc <= i_redirect_pc;
                        // Old address already granted: its response must be dropped.
                        if (w_gnt) begin
                            r_state <= WAIT;
                            r_kill  <= 1'b1;
                        end
                    end else if (!w_aligned) begin
                        r_instr       <= NOP_WORD;
                        r_pc_out      <= r_pc;
                        r_fetch_fault <= 1'b1;
                        r_fetch_ready <= 1'b1;
                        r_state       <= HOLD;
                    end else if (w_gnt) begin
                        r_state <= WAIT;
                    end
                end

                WAIT: begin
                    if (i_redirect_valid) begin
                        r_pc <= i_redirect_pc;
                        if (imem.rvalid) begin
                            r_kill  <= 1'b0;
                            r_state <= REQ;
                        end else begin
                            r_kill <= 1'b1;
                        end
                    end else if (imem.rvalid) begin
                        if (r_kill) begin
                            r_kill  <= 1'b0;
                            r_state <= REQ;
                        end else begin
                            r_instr       <= imem.err ? NOP_WORD : imem.rdata;
                            r_pc_out      <= r_pc;
                            r_fetch_fault <= imem.err;
                            r_fetch_ready <= 1'b1;
                            r_pc          <= r_pc + XLEN'(4);
                            r_state       <= HOLD;
                        end
                    end
                end

                HOLD: begin
                    // Redirect wins over a same-cycle accept: the held word is squashed.
                    if (i_redirect_valid) begin
                        r_pc          <= i_redirect_pc;
                        r_fetch_ready <= 1'b0;
                        r_instr       <= NOP_WORD;
                        r_fetch_fault <= 1'b0;
                        r_state       <= REQ;
                    end else if (!i_stall_fc) begin
                        r_fetch_ready <= 1'b0;
                        r_instr       <= NOP_WORD;
                        r_fetch_fault <= 1'b0;
                        r_fetch_count <= r_fetch_count + 32'd1;
                        r_state       <= REQ;
                    end
                end

                default: begin
                    r_state <= BOOT;
                end
            endcase
        end
    end

`ifndef SYNTHESIS
    a_req_aligned : assert property (@(posedge clk) disable iff (!reset)
        imem.req |-> (imem.addr[1:0] == 2'b00));

    a_ready_in_hold : assert property (@(posedge clk) disable iff (!reset)
        r_fetch_ready == (r_state == HOLD));

    a_kill_only_waiting : assert property (@(posedge clk) disable iff (!reset)
        r_kill |-> (r_state == WAIT));
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Directed scenarios plus a randomized run against a transaction-level fetch model.
module tb_fetch_unit;
    import fetch_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall_fc;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        fetch_ready;
    logic [31:0] instr;
    logic [31:0] pc_out;
    logic        fetch_fault;
    logic [31:0] fetch_count;

    int n_cmp = 0;
    int n_err = 0;

    localparam logic [31:0] NOP = 32'h0000_0013;

    fetch_if #(.XLEN(32)) imem_bus ();

    fetch_unit #(
        .XLEN    (32),
        .RESET_PC(32'h0)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .i_stall_fc      (stall_fc),
        .i_redirect_valid(redirect_valid),
        .i_redirect_pc   (redirect_pc),
        .imem            (imem_bus),
        .o_fetch_ready   (fetch_ready),
        .o_instr         (instr),
        .o_pc_out        (pc_out),
        .o_fetch_fault   (fetch_fault),
        .o_fetch_count   (fetch_count)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] memfn(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        stall_fc        = 1'b0;
        redirect_valid  = 1'b0;
        redirect_pc     = '0;
        imem_bus.gnt    = 1'b0;
        imem_bus.rvalid = 1'b0;
        imem_bus.rdata  = '0;
        imem_bus.err    = 1'b0;
    endtask

    // Leaves the DUT in its first cycle after reset release (BOOT).
    task automatic do_reset();
        reset = 1'b0;
        clear_inputs();
        step();
        step();
        reset = 1'b1;
    endtask

    // From a REQ cycle: grant, respond next cycle; returns in the HOLD cycle.
    task automatic serve(input logic [31:0] data, input logic err);
        imem_bus.gnt = 1'b1;
        step();
        imem_bus.gnt    = 1'b0;
        imem_bus.rvalid = 1'b1;
        imem_bus.rdata  = data;
        imem_bus.err    = err;
        step();
        imem_bus.rvalid = 1'b0;
        imem_bus.err    = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        clear_inputs();
        step();
        n_cmp++;
        if ({imem_bus.req, imem_bus.addr, fetch_ready, instr, pc_out, fetch_fault, fetch_count}
            !== {1'b0, 32'h0, 1'b0, NOP, 32'h0, 1'b0, 32'h0}) begin
            n_err++;
            $display("FAIL reset_values: req=%b addr=%h rdy=%b instr=%h pc=%h flt=%b cnt=%0d",
                     imem_bus.req, imem_bus.addr, fetch_ready, instr, pc_out, fetch_fault,
                     fetch_count);
        end
        reset = 1'b1;
        n_cmp++;
        if ({imem_bus.req, fetch_ready} !== 2'b00) begin
            n_err++;
            $display("FAIL boot_idle: req=%b rdy=%b, want 0 0", imem_bus.req, fetch_ready);
        end
    endtask

    task automatic test_basic();
        step();
        n_cmp++;
        if ({imem_bus.req, imem_bus.addr} !== {1'b1, 32'h0}) begin
            n_err++;
            $display("FAIL first_req: req=%b addr=%h, want 1 0", imem_bus.req, imem_bus.addr);
        end
        serve(32'h0050_0093, 1'b0);
        n_cmp++;
        if ({fetch_ready, instr, pc_out, fetch_fault, fetch_count}
            !== {1'b1, 32'h0050_0093, 32'h0, 1'b0, 32'd0}) begin
            n_err++;
            $display("FAIL first_insn: rdy=%b instr=%h pc=%h flt=%b cnt=%0d",
                     fetch_ready, instr, pc_out, fetch_fault, fetch_count);
        end
        step();
        n_cmp++;
        if ({fetch_ready, fetch_count, imem_bus.req, imem_bus.addr}
            !== {1'b0, 32'd1, 1'b1, 32'h4}) begin
            n_err++;
            $display("FAIL after_accept: rdy=%b cnt=%0d req=%b addr=%h, want 0 1 1 4",
                     fetch_ready, fetch_count, imem_bus.req, imem_bus.addr);
        end
        serve(memfn(32'h4), 1'b0);
        n_cmp++;
        if ({fetch_ready, instr, pc_out} !== {1'b1, memfn(32'h4), 32'h4}) begin
            n_err++;
            $display("FAIL second_insn: rdy=%b instr=%h pc=%h", fetch_ready, instr, pc_out);
        end
        step();
    endtask

    task automatic test_stall();
        serve(32'h1234_5678, 1'b0);
        stall_fc = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            n_cmp++;
            if ({fetch_ready, instr, pc_out, imem_bus.req, fetch_count}
                !== {1'b1, 32'h1234_5678, 32'h8, 1'b0, 32'd2}) begin
                n_err++;
                $display("FAIL stall_hold[%0d]: rdy=%b instr=%h pc=%h req=%b cnt=%0d",
                         i, fetch_ready, instr, pc_out, imem_bus.req, fetch_count);
            end
        end
        stall_fc = 1'b0;
        step();
        n_cmp++;
        if ({fetch_ready, fetch_count, imem_bus.addr} !== {1'b0, 32'd3, 32'hC}) begin
            n_err++;
            $display("FAIL stall_release: rdy=%b cnt=%0d addr=%h, want 0 3 c",
                     fetch_ready, fetch_count, imem_bus.addr);
        end
    endtask

    task automatic test_redirect_wait();
        imem_bus.gnt = 1'b1;
        step();
        imem_bus.gnt   = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h100;
        step();
        redirect_valid = 1'b0;
        step();
        imem_bus.rvalid = 1'b1;
        imem_bus.rdata  = 32'hDEAD_BEEF;
        step();
        imem_bus.rvalid = 1'b0;
        n_cmp++;
        if ({fetch_ready, imem_bus.req, imem_bus.addr} !== {1'b0, 1'b1, 32'h100}) begin
            n_err++;
            $display("FAIL redirect_wait_addr: rdy=%b req=%b addr=%h, want 0 1 100",
                     fetch_ready, imem_bus.req, imem_bus.addr);
        end
        serve(memfn(32'h100), 1'b0);
        n_cmp++;
        if ({fetch_ready, instr, pc_out} !== {1'b1, memfn(32'h100), 32'h100}) begin
            n_err++;
            $display("FAIL redirect_wait_insn: rdy=%b instr=%h pc=%h", fetch_ready, instr, pc_out);
        end
        step();
    endtask

    task automatic test_redirect_hold();
        serve(memfn(32'h104), 1'b0);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h200;
        step();
        redirect_valid = 1'b0;
        n_cmp++;
        if ({fetch_ready, fetch_count, imem_bus.req, imem_bus.addr}
            !== {1'b0, 32'd4, 1'b1, 32'h200}) begin
            n_err++;
            $display("FAIL redirect_hold: rdy=%b cnt=%0d req=%b addr=%h, want 0 4 1 200",
                     fetch_ready, fetch_count, imem_bus.req, imem_bus.addr);
        end
    endtask

    task automatic test_misaligned();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h102;
        step();
        redirect_valid = 1'b0;
        n_cmp++;
        if (imem_bus.req !== 1'b0) begin
            n_err++;
            $display("FAIL misaligned_noreq: req=%b addr=%h, want req 0", imem_bus.req,
                     imem_bus.addr);
        end
        step();
        n_cmp++;
        if ({fetch_ready, fetch_fault, instr, pc_out} !== {1'b1, 1'b1, NOP, 32'h102}) begin
            n_err++;
            $display("FAIL misaligned_fault: rdy=%b flt=%b instr=%h pc=%h",
                     fetch_ready, fetch_fault, instr, pc_out);
        end
        step();
        n_cmp++;
        if ({fetch_count, imem_bus.req} !== {32'd5, 1'b0}) begin
            n_err++;
            $display("FAIL misaligned_consume: cnt=%0d req=%b, want 5 0", fetch_count,
                     imem_bus.req);
        end
        redirect_valid = 1'b1;
        redirect_pc    = 32'h300;
        step();
        redirect_valid = 1'b0;
    endtask

    task automatic test_bus_error();
        n_cmp++;
        if ({imem_bus.req, imem_bus.addr} !== {1'b1, 32'h300}) begin
            n_err++;
            $display("FAIL recover_req: req=%b addr=%h, want 1 300", imem_bus.req, imem_bus.addr);
        end
        serve(32'hCAFE_F00D, 1'b1);
        n_cmp++;
        if ({fetch_ready, fetch_fault, instr, pc_out} !== {1'b1, 1'b1, NOP, 32'h300}) begin
            n_err++;
            $display("FAIL bus_error: rdy=%b flt=%b instr=%h pc=%h",
                     fetch_ready, fetch_fault, instr, pc_out);
        end
        step();
        n_cmp++;
        if ({fetch_count, imem_bus.addr} !== {32'd6, 32'h304}) begin
            n_err++;
            $display("FAIL bus_error_next: cnt=%0d addr=%h, want 6 304", fetch_count,
                     imem_bus.addr);
        end
    endtask

    task automatic test_reset_in_wait();
        imem_bus.gnt = 1'b1;
        step();
        imem_bus.gnt = 1'b0;
        #2;
        reset = 1'b0;
        #1;
        n_cmp++;
        if ({imem_bus.req, imem_bus.addr, fetch_ready, instr, pc_out, fetch_fault, fetch_count}
            !== {1'b0, 32'h0, 1'b0, NOP, 32'h0, 1'b0, 32'h0}) begin
            n_err++;
            $display("FAIL reset_in_wait: req=%b addr=%h rdy=%b instr=%h pc=%h flt=%b cnt=%0d",
                     imem_bus.req, imem_bus.addr, fetch_ready, instr, pc_out, fetch_fault,
                     fetch_count);
        end
        step();
        reset = 1'b1;
        imem_bus.rvalid = 1'b1;
        imem_bus.rdata  = 32'hBAD0_BAD0;
        step();
        imem_bus.rvalid = 1'b0;
        step();
        n_cmp++;
        if ({fetch_ready, imem_bus.req, imem_bus.addr} !== {1'b0, 1'b1, 32'h0}) begin
            n_err++;
            $display("FAIL stale_rvalid: rdy=%b req=%b addr=%h, want 0 1 0",
                     fetch_ready, imem_bus.req, imem_bus.addr);
        end
    endtask

    task automatic test_random();
        logic [31:0] model_pc, out_addr, tgt;
        logic [31:0] h_pc, h_instr, e_pc, e_instr;
        logic        h_fault, e_fault, h_valid, e_now, outst, taint, err_b;
        logic        redir, stall, gnt_now, rv_now;
        int unsigned wait_cnt;
        logic [31:0] exp_cnt;

        do_reset();
        model_pc = 32'h0;
        exp_cnt  = '0;
        h_valid  = 1'b0;
        e_now    = 1'b0;
        outst    = 1'b0;
        taint    = 1'b0;
        wait_cnt = 0;
        {h_pc, h_instr, h_fault, e_pc, e_instr, e_fault, out_addr} = '0;

        for (int cyc = 0; cyc < 4000; cyc++) begin
            n_cmp++;
            if (fetch_count !== exp_cnt) begin
                n_err++;
                $display("FAIL rnd_count@%0d: got %0d want %0d", cyc, fetch_count, exp_cnt);
            end
            if (e_now) begin
                h_valid = 1'b1;
                h_pc    = e_pc;
                h_instr = e_instr;
                h_fault = e_fault;
                e_now   = 1'b0;
            end else if (!h_valid && fetch_ready) begin
                // Only a misaligned target may surface without a bus response.
                n_cmp++;
                if (model_pc[1:0] == 2'b00) begin
                    n_err++;
                    $display("FAIL rnd_unexpected@%0d: ready with aligned pc %h", cyc, model_pc);
                end
                h_valid = 1'b1;
                h_pc    = model_pc;
                h_instr = NOP;
                h_fault = 1'b1;
            end
            n_cmp++;
            if (h_valid) begin
                if ({fetch_ready, instr, pc_out, fetch_fault}
                    !== {1'b1, h_instr, h_pc, h_fault}) begin
                    n_err++;
                    $display("FAIL rnd_present@%0d: got %b %h %h %b want 1 %h %h %b", cyc,
                             fetch_ready, instr, pc_out, fetch_fault, h_instr, h_pc, h_fault);
                end
            end else if (fetch_ready !== 1'b0) begin
                n_err++;
                $display("FAIL rnd_idle@%0d: ready=%b want 0", cyc, fetch_ready);
            end
            if (imem_bus.req) begin
                n_cmp++;
                if (imem_bus.addr !== model_pc || model_pc[1:0] != 2'b00) begin
                    n_err++;
                    $display("FAIL rnd_addr@%0d: got %h want %h", cyc, imem_bus.addr, model_pc);
                end
            end

            redir = ($urandom_range(0, 99) < 6);
            stall = ($urandom_range(0, 99) < 40);
            tgt   = {22'd0, 8'($urandom_range(0, 255)), 2'b00};
            if ($urandom_range(0, 9) == 0) tgt = 32'hFFFF_FFF0;
            if ($urandom_range(0, 6) == 0) tgt[1:0] = 2'($urandom_range(1, 3));
            rv_now = 1'b0;
            if (outst) begin
                wait_cnt--;
                if (wait_cnt == 0) rv_now = 1'b1;
            end
            gnt_now = imem_bus.req && !outst && ($urandom_range(0, 99) < 60);
            err_b   = ($urandom_range(0, 99) < 10);

            if (h_valid && (redir || !stall)) begin
                if (!redir) exp_cnt++;
                h_valid = 1'b0;
            end
            if (rv_now) begin
                if (redir) taint = 1'b1;
                if (!taint) begin
                    e_now    = 1'b1;
                    e_pc     = out_addr;
                    e_fault  = err_b;
                    e_instr  = err_b ? NOP : memfn(out_addr);
                    model_pc = out_addr + 32'd4;
                end
                outst = 1'b0;
            end else if (outst && redir) begin
                taint = 1'b1;
            end
            if (gnt_now) begin
                outst    = 1'b1;
                out_addr = imem_bus.addr;
                taint    = redir;
                wait_cnt = $urandom_range(1, 3);
            end
            if (redir) model_pc = tgt;

            stall_fc        = stall;
            redirect_valid  = redir;
            redirect_pc     = tgt;
            imem_bus.gnt    = gnt_now;
            imem_bus.rvalid = rv_now;
            imem_bus.rdata  = rv_now ? memfn(out_addr) : $urandom;
            imem_bus.err    = rv_now ? err_b : 1'($urandom_range(0, 1));
            step();
        end
        clear_inputs();
    endtask

    initial begin
        reset = 1'b0;
        clear_inputs();
        test_reset();
        test_basic();
        test_stall();
        test_redirect_wait();
        test_redirect_hold();
        test_misaligned();
        test_bus_error();
        test_reset_in_wait();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
